// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
//   Types and defaults shared by the weight tile reader and its tile buffer.
//   - tile_rd_state_e : tile reader FSM states
//   - DEF_DATA_WIDTH / DEF_DATA_LENGTH : default element width and elements
//     per SRAM word
//   - idx_width()     : index width for n entries, never narrower than 1 bit
// ---------------------------------------------------------------------------
package router_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_DATA_LENGTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        LOADED = 2'd3
    } tile_rd_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : router_pkg

// File: rtl/weight_tile_reader_tile_buffer.sv
// ---------------------------------------------------------------------------
// tile_buffer
//   Local storage for one weight tile: TILE_DEPTH SRAM words of DATA_LENGTH
//   elements each. One word-wide write port, one element-wide registered
//   read port (latency 1; output holds when no read is requested).
// Ports
//   i_clk, i_nrst  clock, async active-low reset (read register only)
//   i_clear        sync clear of the read register
//   i_wr_en        write i_wr_data into word i_wr_idx
//   i_rd_en        register element i_rd_elem of word i_rd_idx into o_rd_data
//   o_rd_data      last element read
// ---------------------------------------------------------------------------
module tile_buffer
    import router_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DATA_LENGTH = DEF_DATA_LENGTH,
    parameter int TILE_DEPTH  = 16,
    localparam int IDX_W      = idx_width(TILE_DEPTH),
    localparam int ELEM_W     = idx_width(DATA_LENGTH)
) (
    input  logic                              i_clk,
    input  logic                              i_nrst,
    input  logic                              i_clear,
    input  logic                              i_wr_en,
    input  logic [IDX_W-1:0]                  i_wr_idx,
    input  logic [DATA_LENGTH*DATA_WIDTH-1:0] i_wr_data,
    input  logic                              i_rd_en,
    input  logic [IDX_W-1:0]                  i_rd_idx,
    input  logic [ELEM_W-1:0]                 i_rd_elem,
    output logic [DATA_WIDTH-1:0]             o_rd_data
);

    // Packed element view: element 0 sits in the word's LSBs.
    logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0] mem [TILE_DEPTH];

    // NOTE: storage array has no reset; readers only see words already written,
    // so resetting it would only add a reset net to every bit.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_rd_data <= '0;
        end else if (i_clear) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= mem[i_rd_idx][i_rd_elem];
        end
    end

endmodule : tile_buffer

// File: rtl/weight_tile_reader.sv
// ---------------------------------------------------------------------------
// weight_tile_reader
//   Loads a tile of SRAM words (one read per cycle) into a local buffer and
//   streams it out one element per pop while loading is still in progress.
//   i_data_out_reset replays the buffered tile without touching SRAM.
// Ports
//   i_clk, i_nrst, i_reg_clear             clock, async reset, sync clear
//   i_start, i_base_addr, i_tile_len       tile request
//   o_sram_read_en, o_read_addr            SRAM read request (registered)
//   i_sram_data_valid, i_sram_data         SRAM return beats
//   i_data_out_en, i_data_out_reset        pop / rewind output cursor
//   o_data, o_data_valid                   popped element (latency 1)
//   o_empty, o_full, o_busy, o_done        status
// ---------------------------------------------------------------------------
module weight_tile_reader
    import router_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DATA_LENGTH = DEF_DATA_LENGTH,
    parameter int TILE_DEPTH  = 16
) (
    input  logic                              i_clk,
    input  logic                              i_nrst,
    input  logic                              i_reg_clear,
    input  logic                              i_start,
    input  logic [ADDR_WIDTH-1:0]             i_base_addr,
    input  logic [ADDR_WIDTH-1:0]             i_tile_len,
    output logic                              o_sram_read_en,
    output logic [ADDR_WIDTH-1:0]             o_read_addr,
    input  logic                              i_sram_data_valid,
    input  logic [DATA_LENGTH*DATA_WIDTH-1:0] i_sram_data,
    input  logic                              i_data_out_en,
    input  logic                              i_data_out_reset,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic                              o_data_valid,
    output logic                              o_empty,
    output logic                              o_full,
    output logic                              o_busy,
    output logic                              o_done
);

    localparam int CNT_W  = $clog2(TILE_DEPTH + 1);
    localparam int IDX_W  = idx_width(TILE_DEPTH);
    localparam int ELEM_W = idx_width(DATA_LENGTH);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(TILE_DEPTH);
    localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(DATA_LENGTH - 1);

    tile_rd_state_e        state;
    logic [ADDR_WIDTH-1:0] base;
    logic [CNT_W-1:0]      len_eff;
    logic [CNT_W-1:0]      issue_cnt;    // reads already strobed
    logic [CNT_W-1:0]      wr_cnt;       // words stored in the buffer
    logic [CNT_W-1:0]      word_idx;
    logic [ELEM_W-1:0]     elem_idx;
    logic                  exhausted;    // last element of the tile popped

    logic [CNT_W-1:0]      len_in;
    logic                  start_ok;
    logic                  beat_ok;
    logic                  pop;
    logic                  last_elem;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        len_in    = CNT_W'(i_tile_len);
        if (i_tile_len > ADDR_WIDTH'(TILE_DEPTH)) begin
            len_in = DEPTH_CNT;
        end
        start_ok  = i_start && (state == IDLE || state == LOADED);
        // Beats with nowhere to go (tile complete, or stale after a clear) are dropped.
        beat_ok   = i_sram_data_valid && (state != IDLE) && (wr_cnt != len_eff);
        last_elem = (word_idx == len_eff - CNT_W'(1)) && (elem_idx == LAST_ELEM);
        // Rewind and a new start both override a pop in the same cycle.
        pop       = i_data_out_en && !o_empty && !i_data_out_reset && !start_ok;
    end

    assign o_empty = exhausted || (word_idx >= wr_cnt);
    assign o_full  = (wr_cnt == len_eff) && (state == LOADED);
    assign o_busy  = (state != IDLE);

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state          <= IDLE;
            base           <= '0;
            len_eff        <= '0;
            issue_cnt      <= '0;
            wr_cnt         <= '0;
            word_idx       <= '0;
            elem_idx       <= '0;
            exhausted      <= 1'b0;
            o_sram_read_en <= 1'b0;
            o_read_addr    <= '0;
            o_data_valid   <= 1'b0;
            o_done         <= 1'b0;
        end else if (i_reg_clear) begin
            state          <= IDLE;
            base           <= '0;
            len_eff        <= '0;
            issue_cnt      <= '0;
            wr_cnt         <= '0;
            word_idx       <= '0;
            elem_idx       <= '0;
            exhausted      <= 1'b0;
            o_sram_read_en <= 1'b0;
            o_read_addr    <= '0;
            o_data_valid   <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            o_data_valid <= pop;
            o_done       <= pop && last_elem;

            if (beat_ok) begin
                wr_cnt <= wr_cnt + 1'b1;
            end

            // Output cursor, element-major within each word.
            if (start_ok || i_data_out_reset) begin
                word_idx  <= '0;
                elem_idx  <= '0;
                exhausted <= 1'b0;
            end else if (pop) begin
                if (elem_idx == LAST_ELEM) begin
                    elem_idx <= '0;
                    if (last_elem) begin
                        exhausted <= 1'b1;
                    end else begin
                        word_idx <= word_idx + 1'b1;
                    end
                end else begin
                    elem_idx <= elem_idx + 1'b1;
                end
            end

            case (state)
                IDLE, LOADED: begin
                    if (i_start) begin
                        base      <= i_base_addr;
                        len_eff   <= len_in;
                        wr_cnt    <= '0;
                        if (len_in == '0) begin
                            state  <= IDLE;
                            o_done <= 1'b1;
                        end else begin
                            // First strobe is registered here so it shows the cycle after i_start.
                            state          <= ISSUE;
                            o_sram_read_en <= 1'b1;
                            o_read_addr    <= i_base_addr;
                            issue_cnt      <= CNT_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (issue_cnt == len_eff) begin
                        state          <= WAIT;
                        o_sram_read_en <= 1'b0;
                        o_read_addr    <= '0;
                    end else begin
                        o_read_addr <= base + ADDR_WIDTH'(issue_cnt);
                        issue_cnt   <= issue_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (wr_cnt == len_eff) begin
                        state <= LOADED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    tile_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DATA_LENGTH (DATA_LENGTH),
        .TILE_DEPTH  (TILE_DEPTH)
    ) u_tile_buffer (
        .i_clk     (i_clk),
        .i_nrst    (i_nrst),
        .i_clear   (i_reg_clear),
        .i_wr_en   (beat_ok && !i_reg_clear),
        .i_wr_idx  (wr_cnt[IDX_W-1:0]),
        .i_wr_data (i_sram_data),
        .i_rd_en   (pop),
        .i_rd_idx  (word_idx[IDX_W-1:0]),
        .i_rd_elem (elem_idx),
        .o_rd_data (o_data)
    );

endmodule : weight_tile_reader

// File: tb/tb_weight_tile_reader.sv
// ---------------------------------------------------------------------------
// tb_weight_tile_reader
//   Directed bench for weight_tile_reader with a behavioural SRAM of
//   selectable read latency (1..4). Element e of the word at address a is
//   ((a*4 + e) mod 256) ^ 0xC3, so every element of a tile is distinct.
// ---------------------------------------------------------------------------
module tb_weight_tile_reader;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic        i_reg_clear;
    logic        i_start;
    logic [7:0]  i_base_addr;
    logic [7:0]  i_tile_len;
    logic        o_sram_read_en;
    logic [7:0]  o_read_addr;
    logic        i_sram_data_valid;
    logic [31:0] i_sram_data;
    logic        i_data_out_en;
    logic        i_data_out_reset;
    logic [7:0]  o_data;
    logic        o_data_valid;
    logic        o_empty;
    logic        o_full;
    logic        o_busy;
    logic        o_done;

    int n_cmp  = 0;
    int n_fail = 0;

    weight_tile_reader dut (
        .i_clk             (i_clk),
        .i_nrst            (i_nrst),
        .i_reg_clear       (i_reg_clear),
        .i_start           (i_start),
        .i_base_addr       (i_base_addr),
        .i_tile_len        (i_tile_len),
        .o_sram_read_en    (o_sram_read_en),
        .o_read_addr       (o_read_addr),
        .i_sram_data_valid (i_sram_data_valid),
        .i_sram_data       (i_sram_data),
        .i_data_out_en     (i_data_out_en),
        .i_data_out_reset  (i_data_out_reset),
        .o_data            (o_data),
        .o_data_valid      (o_data_valid),
        .o_empty           (o_empty),
        .o_full            (o_full),
        .o_busy            (o_busy),
        .o_done            (o_done)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] elem_of(input logic [7:0] addr, input int e);
        logic [7:0] v;
        v = addr * 8'd4 + 8'(e);
        return v ^ 8'hC3;
    endfunction

    function automatic logic [31:0] word_of(input logic [7:0] addr);
        return {elem_of(addr, 3), elem_of(addr, 2), elem_of(addr, 1), elem_of(addr, 0)};
    endfunction

    // Behavioural SRAM: strobe seen at edge k returns sram_lat cycles later.
    int         sram_lat = 1;
    logic [4:1] pv;
    logic [7:0] pa [1:4];

    always @(posedge i_clk) begin
        if (!i_nrst) begin
            pv <= '0;
        end else begin
            pv[1] <= o_sram_read_en;
            pa[1] <= o_read_addr;
            for (int k = 2; k <= 4; k++) begin
                pv[k] <= pv[k-1];
                pa[k] <= pa[k-1];
            end
        end
    end

    assign i_sram_data_valid = pv[sram_lat];
    assign i_sram_data       = word_of(pa[sram_lat]);

    // Per-run observation logs (cycle 0 = first edge of the run).
    logic [7:0] strb_addr[$];
    int         strb_cyc[$];
    logic [7:0] elems[$];
    int         elem_cyc[$];
    int         done_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Runs ncyc cycles; i_start and i_data_out_reset are one-cycle pulses.
    task automatic collect(input int ncyc);
        strb_addr.delete();
        strb_cyc.delete();
        elems.delete();
        elem_cyc.delete();
        done_cyc.delete();
        for (int i = 0; i < ncyc; i++) begin
            tick();
            i_start          = 1'b0;
            i_data_out_reset = 1'b0;
            if (o_sram_read_en) begin
                strb_addr.push_back(o_read_addr);
                strb_cyc.push_back(i);
            end
            if (o_data_valid) begin
                elems.push_back(o_data);
                elem_cyc.push_back(i);
            end
            if (o_done) done_cyc.push_back(i);
        end
    endtask

    task automatic check_strobes(input string tag, input logic [7:0] base, input int n);
        check({tag, "_strobe_count"}, strb_addr.size(), n);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_addr%0d", tag, k),
                  (k < strb_addr.size()) ? {24'd0, strb_addr[k]} : 32'hDEAD_BEEF,
                  {24'd0, base + 8'(k)});
        end
        if (n > 0 && strb_cyc.size() == n) begin
            check({tag, "_first_strobe_cycle"}, strb_cyc[0], 0);
            check({tag, "_back_to_back"}, strb_cyc[n-1] - strb_cyc[0], n - 1);
        end
    endtask

    task automatic check_stream(input string tag, input logic [7:0] base, input int nwords);
        check({tag, "_elem_count"}, elems.size(), nwords * 4);
        for (int k = 0; k < nwords * 4; k++) begin
            check($sformatf("%s_w%0de%0d", tag, k / 4, k % 4),
                  (k < elems.size()) ? {24'd0, elems[k]} : 32'hDEAD_BEEF,
                  {24'd0, elem_of(base + 8'(k / 4), k % 4)});
        end
        check({tag, "_done_count"}, done_cyc.size(), 1);
        if (done_cyc.size() == 1 && elem_cyc.size() == nwords * 4) begin
            check({tag, "_done_with_last"}, done_cyc[0], elem_cyc[nwords*4-1]);
        end
    endtask

    initial begin
        i_nrst           = 1'b0;
        i_reg_clear      = 1'b0;
        i_start          = 1'b0;
        i_base_addr      = '0;
        i_tile_len       = '0;
        i_data_out_en    = 1'b0;
        i_data_out_reset = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_empty",   o_empty,        1);
        check("rst_busy",    o_busy,         0);
        check("rst_read_en", o_sram_read_en, 0);
        check("rst_addr",    o_read_addr,    0);
        check("rst_data",    o_data,         0);
        check("rst_valid",   o_data_valid,   0);
        check("rst_full",    o_full,         0);
        check("rst_done",    o_done,         0);
        i_nrst = 1'b1;
        tick();

        // Cases 1+2: base 0x10, len 4, latency 1, popping throughout the load
        sram_lat      = 1;
        i_base_addr   = 8'h10;
        i_tile_len    = 8'd4;
        i_data_out_en = 1'b1;
        i_start       = 1'b1;
        collect(30);
        check_strobes("load", 8'h10, 4);
        check_stream("stream", 8'h10, 4);
        if (elem_cyc.size() == 16) check("stream_no_gaps", elem_cyc[15] - elem_cyc[0], 15);
        check("stream_full_after",  o_full,  1);
        check("stream_empty_after", o_empty, 1);
        check("stream_busy_loaded", o_busy,  1);

        // Case 3: replay from the buffer, no SRAM traffic
        i_data_out_en    = 1'b0;
        i_data_out_reset = 1'b1;
        tick();
        i_data_out_reset = 1'b0;
        check("replay_not_empty", o_empty, 0);
        i_data_out_en = 1'b1;
        collect(20);
        check("replay_no_strobes", strb_addr.size(), 0);
        check_stream("replay", 8'h10, 4);
        if (elem_cyc.size() == 16) check("replay_no_gaps", elem_cyc[15] - elem_cyc[0], 15);

        // Case 4a: address wrap, new tile started from LOADED
        i_data_out_en = 1'b0;
        i_base_addr   = 8'hFE;
        i_tile_len    = 8'd4;
        i_start       = 1'b1;
        collect(12);
        check_strobes("wrap", 8'hFE, 4);
        check("wrap_full", o_full, 1);

        // Case 4b: zero-length tile from IDLE
        i_reg_clear = 1'b1;
        tick();
        i_reg_clear = 1'b0;
        check("clear_busy", o_busy, 0);
        i_tile_len = 8'd0;
        i_start    = 1'b1;
        collect(4);
        check("len0_strobes", strb_addr.size(), 0);
        check("len0_done_count", done_cyc.size(), 1);
        if (done_cyc.size() == 1) check("len0_done_cycle", done_cyc[0], 0);
        check("len0_busy", o_busy, 0);

        // Case 4c: oversize tile clamps to 16 reads
        i_base_addr = 8'h20;
        i_tile_len  = 8'd40;
        i_start     = 1'b1;
        collect(25);
        check_strobes("clamp", 8'h20, 16);
        check("clamp_full", o_full, 1);

        // Case 5: clear in WAIT with two beats in flight (latency 3)
        sram_lat    = 3;
        i_base_addr = 8'h40;
        i_tile_len  = 8'd4;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (5) tick();
        check("pre_clear_wait", o_sram_read_en, 0);
        check("pre_clear_busy", o_busy, 1);
        i_reg_clear = 1'b1;
        tick();
        i_reg_clear = 1'b0;
        check("clear_wait_busy",  o_busy,  0);
        check("clear_wait_empty", o_empty, 1);
        check("clear_wait_full",  o_full,  0);
        repeat (4) tick();
        check("stale_beats_dropped", o_empty, 1);
        i_base_addr   = 8'h80;
        i_tile_len    = 8'd2;
        i_data_out_en = 1'b1;
        i_start       = 1'b1;
        collect(25);
        check_strobes("reload", 8'h80, 2);
        check_stream("reload", 8'h80, 2);

        // Case 6: rewind beats a simultaneous pop; pop while empty ignored
        i_data_out_en    = 1'b1;
        i_data_out_reset = 1'b1;
        tick();
        i_data_out_reset = 1'b0;
        check("rewind_pop_dropped", o_data_valid, 0);
        tick();
        check("rewind_next_valid", o_data_valid, 1);
        check("rewind_next_w0e0",  o_data,       {24'd0, elem_of(8'h80, 0)});
        i_data_out_en = 1'b0;
        i_reg_clear   = 1'b1;
        tick();
        i_reg_clear   = 1'b0;
        i_data_out_en = 1'b1;
        tick();
        check("empty_pop_valid", o_data_valid, 0);
        check("empty_pop_data",  o_data,       0);
        i_data_out_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_weight_tile_reader
